mod_sub_serial: RTL and testbench



---
 rtl/ecc_arith_pkg.sv | 16 +
 rtl/digit_addsub.sv | 28 ++
 rtl/mod_sub_serial.sv | 158 +++++++++++++++
 tb/tb_mod_sub_serial.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ecc_arith_pkg.sv
// Shared constants and types for the digit-serial ECC arithmetic blocks.
package ecc_arith_pkg;

    localparam int WIDTH      = 256;
    localparam int DIGIT      = 8;
    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_CORR = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/digit_addsub.sv
// Combinational DIGIT-bit adder/subtractor.
// sub=1: {borrow_out, r} = x - y - borrow_in (cin/cout act as borrows).
// sub=0: {carry_out,  r} = x + y + carry_in.
module digit_addsub
    import ecc_arith_pkg::*;
(
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic [DIGIT-1:0] r,
    output logic             cout
);

    logic [DIGIT:0]   t;
    logic [DIGIT-1:0] y_op;
    logic             c_op;

    // Subtraction as x + ~y + ~borrow; the carry out of that sum is the inverted borrow.
    always_comb begin
        y_op = sub ? ~y : y;
        c_op = sub ? ~cin : cin;
        t    = {1'b0, x} + {1'b0, y_op} + {{DIGIT{1'b0}}, c_op};
        r    = t[DIGIT-1:0];
        cout = sub ? ~t[DIGIT] : t[DIGIT];
    end

endmodule

// File: rtl/mod_sub_serial.sv
// Digit-serial 256-bit modular subtractor: diff = (a - b) mod p, LSB digit first.
// Build option: MODSUB_CONST_TIME_EN -- always run the correction pass (adding p
// masked by the borrow) so latency does not depend on operand values.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | in_ready high, waiting for operands
// SUB   | one digit of a - b per cycle, borrow carried in cy
// CORR  | one digit of res + p per cycle (only after a borrow, unless const-time)
// DONE  | out_valid high, result held until out_ready
module mod_sub_serial
    import ecc_arith_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             underflow
);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             cy;
    logic             uf;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] res;

    logic [DIGIT-1:0] a_d;
    logic [DIGIT-1:0] b_d;
    logic [DIGIT-1:0] p_d;
    logic [DIGIT-1:0] r_d;
    logic [DIGIT-1:0] op_x;
    logic [DIGIT-1:0] op_y;
    logic [DIGIT-1:0] sum;
    logic             sub_mode;
    logic             cout;
    logic             last;

    assign a_d  = a_r[idx*DIGIT +: DIGIT];
    assign b_d  = b_r[idx*DIGIT +: DIGIT];
    assign p_d  = p_r[idx*DIGIT +: DIGIT];
    assign r_d  = res[idx*DIGIT +: DIGIT];
    assign last = (idx == IDX_W'(NUM_DIGITS - 1));

    // One adder shared by the subtract and correction passes.
    digit_addsub u_addsub (
        .x    (op_x),
        .y    (op_y),
        .cin  (cy),
        .sub  (sub_mode),
        .r    (sum),
        .cout (cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_SUB;
            ST_SUB: begin
                if (last) begin
`ifdef MODSUB_CONST_TIME_EN
                    state_nxt = ST_CORR;
`else
                    state_nxt = cout ? ST_CORR : ST_DONE;
`endif
                end
            end
            ST_CORR: if (last) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs and adder operand selection.
    always_comb begin
        in_ready  = (state == ST_IDLE) && !rst;
        out_valid = (state == ST_DONE);
        sub_mode  = (state == ST_SUB);
        op_x      = a_d;
        op_y      = b_d;
        if (state == ST_CORR) begin
            op_x = r_d;
`ifdef MODSUB_CONST_TIME_EN
            op_y = p_d & {DIGIT{uf}};
`else
            op_y = p_d;
`endif
        end
    end

    // Operand latches, digit index, borrow/carry chain and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            cy  <= 1'b0;
            uf  <= 1'b0;
            a_r <= '0;
            b_r <= '0;
            p_r <= '0;
            res <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        b_r <= b;
                        p_r <= p;
                        idx <= '0;
                        cy  <= 1'b0;
                    end
                end
                ST_SUB: begin
                    res[idx*DIGIT +: DIGIT] <= sum;
                    if (last) begin
                        idx <= '0;
                        cy  <= 1'b0;
                        uf  <= cout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                        cy  <= cout;
                    end
                end
                ST_CORR: begin
                    // Carry out of the top digit is dropped: the sum wraps mod 2^WIDTH.
                    res[idx*DIGIT +: DIGIT] <= sum;
                    if (last) begin
                        idx <= '0;
                        cy  <= 1'b0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                        cy  <= cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff      = res;
    assign underflow = uf;

endmodule

// File: tb/tb_mod_sub_serial.sv
// Self-checking bench for mod_sub_serial against a plain-arithmetic reference.
module tb_mod_sub_serial;
    import ecc_arith_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] p;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             underflow;

    int n_checks = 0;
    int n_pass   = 0;

    mod_sub_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .p         (p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Operands are launched at a negedge; that cycle is the accept cycle T.
    task automatic run_op(input logic [255:0] ta, input logic [255:0] tbv,
                          input logic [255:0] tp, input int hold, input bit poke);
        logic [255:0] exp_d;
        logic         exp_u;
        int           exp_lat;
        int           lat;
        int           w;
        exp_u = (ta < tbv);
        exp_d = exp_u ? (ta - tbv + tp) : (ta - tbv);
`ifdef MODSUB_CONST_TIME_EN
        exp_lat = 2 * NUM_DIGITS + 1;
`else
        exp_lat = exp_u ? 2 * NUM_DIGITS + 1 : NUM_DIGITS + 1;
`endif
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_idle", 256'(in_ready), 256'd1);
        a = ta; b = tbv; p = tp; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = rnd256(); b = rnd256(); p = rnd256();
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (lat == 2) chk("busy_in_ready", 256'(in_ready), 256'd0);
            if (poke && lat == 3) begin
                in_valid = 1'b1;
                a = rnd256(); b = rnd256(); p = rnd256();
            end
            if (poke && lat == 6) in_valid = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("latency", 256'(lat), 256'(exp_lat));
        chk("diff", diff, exp_d);
        chk("underflow", 256'(underflow), 256'(exp_u));
        chk("done_in_ready", 256'(in_ready), 256'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_out_valid", 256'(out_valid), 256'd1);
            chk("hold_diff", diff, exp_d);
            chk("hold_underflow", 256'(underflow), 256'(exp_u));
            chk("hold_in_ready", 256'(in_ready), 256'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", 256'(out_valid), 256'd0);
        chk("post_in_ready", 256'(in_ready), 256'd1);
        chk("post_diff_kept", diff, exp_d);
    endtask

    initial begin
        logic [255:0] ra;
        logic [255:0] rb;
        logic [255:0] rp;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; p = '0;

        // Reset values.
        @(negedge clk);
        chk("rst_in_ready", 256'(in_ready), 256'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready_after", 256'(in_ready), 256'd1);
        chk("rst_out_valid", 256'(out_valid), 256'd0);
        chk("rst_diff", diff, 256'd0);
        chk("rst_underflow", 256'(underflow), 256'd0);
        @(negedge clk);

        // Directed cases.
        run_op(256'd5, 256'd3, 256'd7, 0, 1'b0);
        run_op(256'd3, 256'd5, 256'd7, 0, 1'b0);
        run_op(256'd0, 256'd1, {256{1'b1}}, 0, 1'b0);
        run_op(256'h1234, 256'h1234, (256'd1 << 255) - 256'd19, 5, 1'b0);

        // Reset in the 10th SUB cycle.
        a = 256'd100; b = 256'd1; p = 256'd1001; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", 256'(in_ready), 256'd1);
        chk("midrst_out_valid", 256'(out_valid), 256'd0);
        chk("midrst_diff", diff, 256'd0);
        chk("midrst_underflow", 256'(underflow), 256'd0);
        @(negedge clk);
        run_op(256'd9, 256'd4, 256'd11, 0, 1'b0);

        // in_valid while busy is ignored; the next op is then accepted normally.
        run_op(256'd20, 256'd30, 256'd37, 0, 1'b1);
        run_op(256'd31, 256'd2, 256'd37, 0, 1'b0);

        // Randomized operands below a random odd modulus.
        for (int k = 0; k < 16; k++) begin
            if (k % 3 == 0) rp = 256'($urandom_range(1000, 3)) | 256'd1;
            else            rp = rnd256() | 256'd1;
            ra = rnd256() % rp;
            rb = (k % 5 == 4) ? ra : rnd256() % rp;
            run_op(ra, rb, rp, (k % 4 == 1) ? 2 : 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
